// File: rtl/slot_io_pkg.sv
// slot_io_pkg: state encodings and default timeout shared by the slot responder and dock-side benches
package slot_io_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;
  localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/slot_io_timer.sv
// slot_io_timer: 8-bit saturating cycle counter with clear, enable and expiry flag
module slot_io_timer #(
  parameter int LIMIT = 15
)(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);
  logic [7:0] count;
  // expired is true in the cycle whose increment brings the count to LIMIT
  assign expired = count >= 8'(LIMIT - 1);
  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (en && count != 8'hFF) count <= count + 8'd1;
  end
endmodule

// File: rtl/slot_io_responder.sv
// slot_io_responder: dock I/O slot target bridging strobed bus cycles to a local req/ack register port
module slot_io_responder
  import slot_io_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int REG_AW  = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              iorq_n,
  input  logic              r_w_,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        dbus_in,
  output logic [7:0]        dbus_out,
  output logic              dbus_oe,
  output logic              dev_ready_n,
  output logic              loc_req,
  output logic              loc_we,
  output logic [REG_AW-1:0] loc_addr,
  output logic [7:0]        loc_wdata,
  input  logic [7:0]        loc_rdata,
  input  logic              loc_ack,
  output logic              err_timeout
);
  state_t state, nxt;
  logic sel, armed, start, expired, cap, load_ff, set_err;
  logic [7:0] rd_reg;
  logic unused_addr;
  assign unused_addr = ^addr[ADDR_W-1:REG_AW];
  assign sel = !cs_n && !iorq_n;
  // armed remembers an idle cycle without select, so a held select never retriggers
  assign start = state == IDLE && sel && armed;
  assign loc_req = state == REQ || state == DRAIN;
  assign dev_ready_n = rst || !(sel && (state == IDLE || state == REQ));
  assign dbus_oe = !rst && state == HOLD && sel && r_w_;
  assign dbus_out = rd_reg;
  slot_io_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .clear(start), .en(loc_req), .expired(expired)
  );
  always_comb begin
    nxt = state;
    cap = 1'b0;
    load_ff = 1'b0;
    set_err = 1'b0;
    case (state)
      IDLE: nxt = start ? REQ : IDLE;
      REQ:
        if (loc_ack) begin
          nxt = sel ? HOLD : IDLE;
          cap = sel && !loc_we;
        end else if (!sel) nxt = DRAIN;
        else if (expired) begin
          nxt = HOLD;
          load_ff = 1'b1;
          set_err = 1'b1;
        end
      HOLD: nxt = sel ? HOLD : IDLE;
      DRAIN: begin
        nxt = (loc_ack || expired) ? IDLE : DRAIN;
        set_err = !loc_ack && expired;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      armed <= 1'b0;
      loc_we <= 1'b0;
      loc_addr <= '0;
      loc_wdata <= '0;
      rd_reg <= 8'hFF;
      err_timeout <= 1'b0;
    end else begin
      state <= nxt;
      armed <= state == IDLE && !sel;
      if (start) begin
        loc_addr <= addr[REG_AW-1:0];
        loc_we <= !r_w_;
        loc_wdata <= dbus_in;
      end
      if (cap) rd_reg <= loc_rdata;
      else if (load_ff) rd_reg <= 8'hFF;
      err_timeout <= err_timeout || set_err;
    end
  end
endmodule

// File: tb/tb_slot_io_responder.sv
// tb_slot_io_responder: table-driven write/read vectors plus timeout, abort, collision and reset sequences
module tb_slot_io_responder;
  logic clk = 0, rst = 1, cs_n = 1, iorq_n = 1, r_w_ = 1, loc_ack = 0;
  logic [7:0] addr = 0, dbus_in = 0, loc_rdata = 0;
  logic [7:0] dbus_out, loc_wdata;
  logic dbus_oe, dev_ready_n, loc_req, loc_we, err_timeout;
  logic [3:0] loc_addr;
  int pass = 0, total = 0;

  slot_io_responder dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .iorq_n(iorq_n), .r_w_(r_w_), .addr(addr),
    .dbus_in(dbus_in), .dbus_out(dbus_out), .dbus_oe(dbus_oe), .dev_ready_n(dev_ready_n),
    .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_rdata(loc_rdata), .loc_ack(loc_ack), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  typedef struct {
    logic sel; logic rw; logic [7:0] addr; logic [7:0] din; logic [7:0] rdata; logic ack;
    logic rdy_n; logic oe; logic req; logic we; logic [3:0] la; logic [7:0] wd; logic [7:0] dout; logic err;
  } vec_t;
  vec_t v[17];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h want %0h", n, a, e);
    else pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic s, input logic rw, input logic [7:0] a, input logic [7:0] d);
    cs_n = !s;
    iorq_n = !s;
    r_w_ = rw;
    addr = a;
    dbus_in = d;
  endtask

  initial begin
    int rises;
    logic prev;
    v[0]  = '{1, 0, 8'h13, 8'hA5, 8'h00, 0,  0, 0, 0, 0, 4'h0, 8'h00, 8'hFF, 0};
    v[1]  = '{1, 0, 8'h13, 8'hA5, 8'h00, 0,  0, 0, 1, 1, 4'h3, 8'hA5, 8'hFF, 0};
    v[2]  = '{1, 0, 8'h13, 8'hA5, 8'h00, 0,  0, 0, 1, 1, 4'h3, 8'hA5, 8'hFF, 0};
    v[3]  = '{1, 0, 8'h13, 8'hA5, 8'h00, 1,  0, 0, 1, 1, 4'h3, 8'hA5, 8'hFF, 0};
    v[4]  = '{1, 0, 8'h13, 8'hA5, 8'h00, 0,  1, 0, 0, 1, 4'h3, 8'hA5, 8'hFF, 0};
    v[5]  = '{0, 0, 8'h13, 8'hA5, 8'h00, 0,  1, 0, 0, 1, 4'h3, 8'hA5, 8'hFF, 0};
    v[6]  = '{0, 1, 8'h31, 8'h00, 8'h00, 0,  1, 0, 0, 1, 4'h3, 8'hA5, 8'hFF, 0};
    v[7]  = '{1, 1, 8'h31, 8'h00, 8'h00, 0,  0, 0, 0, 1, 4'h3, 8'hA5, 8'hFF, 0};
    v[8]  = '{1, 1, 8'h31, 8'h00, 8'h00, 0,  0, 0, 1, 0, 4'h1, 8'h00, 8'hFF, 0};
    v[9]  = v[8];
    v[10] = v[8];
    v[11] = v[8];
    v[12] = '{1, 1, 8'h31, 8'h00, 8'h5C, 1,  0, 0, 1, 0, 4'h1, 8'h00, 8'hFF, 0};
    v[13] = '{1, 1, 8'h31, 8'h00, 8'h00, 0,  1, 1, 0, 0, 4'h1, 8'h00, 8'h5C, 0};
    v[14] = v[13];
    v[15] = '{0, 1, 8'h31, 8'h00, 8'h00, 0,  1, 0, 0, 0, 4'h1, 8'h00, 8'h5C, 0};
    v[16] = '{0, 0, 8'h00, 8'h00, 8'h00, 0,  1, 0, 0, 0, 4'h1, 8'h00, 8'h5C, 0};

    bus(1, 1, 8'h42, 8'h77);
    tick();
    tick();
    chk("rst.rdy", dev_ready_n, 1);
    chk("rst.oe", dbus_oe, 0);
    chk("rst.req", loc_req, 0);
    chk("rst.we", loc_we, 0);
    chk("rst.addr", loc_addr, 0);
    chk("rst.wdata", loc_wdata, 0);
    chk("rst.dout", dbus_out, 8'hFF);
    chk("rst.err", err_timeout, 0);
    rst = 0;
    bus(0, 1, 8'h00, 8'h00);

    for (int i = 0; i < 17; i++) begin
      tick();
      bus(v[i].sel, v[i].rw, v[i].addr, v[i].din);
      loc_rdata = v[i].rdata;
      loc_ack = v[i].ack;
      #1;
      chk($sformatf("r%0d.rdy", i), dev_ready_n, v[i].rdy_n);
      chk($sformatf("r%0d.oe", i), dbus_oe, v[i].oe);
      chk($sformatf("r%0d.req", i), loc_req, v[i].req);
      chk($sformatf("r%0d.we", i), loc_we, v[i].we);
      chk($sformatf("r%0d.addr", i), loc_addr, v[i].la);
      chk($sformatf("r%0d.wdata", i), loc_wdata, v[i].wd);
      chk($sformatf("r%0d.dout", i), dbus_out, v[i].dout);
      chk($sformatf("r%0d.err", i), err_timeout, v[i].err);
    end

    // timeout: read with no ack for 15 REQ cycles
    tick();
    bus(1, 1, 8'h00, 8'h00);
    loc_ack = 0;
    #1;
    chk("to.start_rdy", dev_ready_n, 0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("to.req%0d", i), loc_req, 1);
      chk($sformatf("to.rdy%0d", i), dev_ready_n, 0);
    end
    tick();
    chk("to.hold_rdy", dev_ready_n, 1);
    chk("to.hold_oe", dbus_oe, 1);
    chk("to.hold_dout", dbus_out, 8'hFF);
    chk("to.hold_err", err_timeout, 1);
    chk("to.hold_req", loc_req, 0);
    tick();
    bus(0, 1, 8'h00, 8'h00);
    #1;
    tick();
    chk("to.sticky", err_timeout, 1);

    // abort: sel drops in REQ cycle 2, ack three DRAIN cycles later, sel during DRAIN ignored
    tick();
    bus(1, 0, 8'h05, 8'h11);
    #1;
    tick();
    chk("ab.req1", loc_req, 1);
    chk("ab.addr", loc_addr, 4'h5);
    tick();
    bus(0, 0, 8'h05, 8'h11);
    #1;
    chk("ab.drop_rdy", dev_ready_n, 1);
    chk("ab.drop_req", loc_req, 1);
    tick();
    bus(1, 1, 8'h0A, 8'h22);
    #1;
    chk("ab.d1_req", loc_req, 1);
    chk("ab.d1_rdy", dev_ready_n, 1);
    chk("ab.d1_oe", dbus_oe, 0);
    tick();
    chk("ab.d2_req", loc_req, 1);
    tick();
    loc_ack = 1;
    #1;
    chk("ab.d3_req", loc_req, 1);
    tick();
    loc_ack = 0;
    #1;
    chk("ab.idle_req", loc_req, 0);
    chk("ab.idle_addr", loc_addr, 4'h5);
    tick();
    chk("ab.noretrig_req", loc_req, 0);
    chk("ab.noretrig_we", loc_we, 1);
    tick();
    bus(0, 1, 8'h00, 8'h00);
    #1;

    // collision: ack arrives in the same cycle the timer expires
    tick();
    rst = 1;
    tick();
    chk("col.rst_err", err_timeout, 0);
    rst = 0;
    tick();
    bus(1, 1, 8'h07, 8'h00);
    #1;
    rises = 0;
    prev = loc_req;
    for (int i = 1; i <= 15; i++) begin
      tick();
      loc_ack = i == 15;
      loc_rdata = 8'h77;
      #1;
      if (loc_req && !prev) rises++;
      prev = loc_req;
      chk($sformatf("col.req%0d", i), loc_req, 1);
    end
    tick();
    loc_ack = 0;
    #1;
    chk("col.err", err_timeout, 0);
    chk("col.dout", dbus_out, 8'h77);
    chk("col.oe", dbus_oe, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (loc_req && !prev) rises++;
      prev = loc_req;
      chk($sformatf("col.held%0d", i), loc_req, 0);
    end
    chk("col.one_req", rises, 1);

    // reset during REQ
    tick();
    bus(0, 1, 8'h00, 8'h00);
    #1;
    tick();
    tick();
    bus(1, 1, 8'h02, 8'h00);
    #1;
    tick();
    chk("rq.req", loc_req, 1);
    tick();
    rst = 1;
    #1;
    tick();
    chk("rq.req_after", loc_req, 0);
    chk("rq.rdy_after", dev_ready_n, 1);
    chk("rq.err_after", err_timeout, 0);
    chk("rq.oe_after", dbus_oe, 0);
    rst = 0;
    tick();
    chk("rq.no_retrig1", loc_req, 0);
    tick();
    chk("rq.no_retrig2", loc_req, 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
